// File: rtl/plot_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : plot_pkg
//  Description : Shared constants and types for the plot controller:
//                screen geometry, coordinate/colour widths and the
//                controller state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package plot_pkg;

    localparam int H_RES    = 160;   // horizontal pixels, x = 0..H_RES-1
    localparam int V_RES    = 120;   // vertical pixels,   y = 0..V_RES-1
    localparam int X_W      = 8;     // x coordinate width
    localparam int Y_W      = 7;     // y coordinate width
    localparam int COLOUR_W = 3;     // default colour word width

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_LINE  = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/plot_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : plot_ctrl_if
//  Description : Bundle between a drawing client and the plot controller.
//                Client side : clear_req, clear_colour, line_valid, line_x,
//                              line_y, line_colour  (driven by master)
//                Status      : line_ready, busy, clear_done
//                VGA side    : vga_x, vga_y, vga_colour, vga_plot
//                master = client / VGA-adapter view, slave = controller view.
//  Revision    : 1.0 - initial release
// ============================================================================
interface plot_ctrl_if #(
    parameter int COLOUR_W = plot_pkg::COLOUR_W
);
    import plot_pkg::*;

    logic                clear_req;
    logic [COLOUR_W-1:0] clear_colour;
    logic                line_valid;
    logic [X_W-1:0]      line_x;
    logic [Y_W-1:0]      line_y;
    logic [COLOUR_W-1:0] line_colour;
    logic                line_ready;
    logic                busy;
    logic                clear_done;
    logic [X_W-1:0]      vga_x;
    logic [Y_W-1:0]      vga_y;
    logic [COLOUR_W-1:0] vga_colour;
    logic                vga_plot;

    modport master (
        output clear_req, clear_colour, line_valid, line_x, line_y, line_colour,
        input  line_ready, busy, clear_done, vga_x, vga_y, vga_colour, vga_plot
    );

    modport slave (
        input  clear_req, clear_colour, line_valid, line_x, line_y, line_colour,
        output line_ready, busy, clear_done, vga_x, vga_y, vga_colour, vga_plot
    );

endinterface
`default_nettype wire

// File: rtl/plot_ctrl_xy_sweep.sv
`default_nettype none
// ============================================================================
//  Module      : xy_sweep
//  Description : Raster counter for the screen clear. Advances one pixel per
//                enabled cycle, x fastest, wrapping to (0,0) after the last
//                pixel.
//  Ports       : clk   - clock
//                reset - synchronous, active-low reset (returns to (0,0))
//                en    - advance one position
//                x, y  - current raster position
//                last  - current position is (H_RES-1, V_RES-1)
//  Revision    : 1.0 - initial release
// ============================================================================
module xy_sweep #(
    parameter int H_RES = plot_pkg::H_RES,
    parameter int V_RES = plot_pkg::V_RES,
    parameter int X_W   = plot_pkg::X_W,
    parameter int Y_W   = plot_pkg::Y_W
) (
    input  wire logic           clk,
    input  wire logic           reset,
    input  wire logic           en,
    output logic [X_W-1:0]      x,
    output logic [Y_W-1:0]      y,
    output logic                last
);
    import plot_pkg::*;

    localparam logic [X_W-1:0] c_X_MAX = X_W'(H_RES - 1);
    localparam logic [Y_W-1:0] c_Y_MAX = Y_W'(V_RES - 1);

    logic [X_W-1:0] r_x;
    logic [Y_W-1:0] r_y;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_x <= '0;
            r_y <= '0;
        end else if (en) begin
            if (r_x == c_X_MAX) begin
                r_x <= '0;
                r_y <= (r_y == c_Y_MAX) ? '0 : r_y + 1'b1;
            end else begin
                r_x <= r_x + 1'b1;
            end
        end
    end

    assign x    = r_x;
    assign y    = r_y;
    assign last = (r_x == c_X_MAX) && (r_y == c_Y_MAX);

endmodule
`default_nettype wire

// File: rtl/plot_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : plot_ctrl
//  Description : Arbitrates between a full-screen clear and a pixel stream
//                from a line drawer, producing registered plot commands for
//                a VGA adapter.
//  Ports       : clk   - clock, all logic on the rising edge
//                reset - synchronous, active-low reset
//                bus   - plot_ctrl_if.slave (clear request, line pixel
//                        handshake, status, VGA plot outputs)
//  Revision    : 1.0 - initial release
// ============================================================================
module plot_ctrl #(
    parameter int H_RES    = plot_pkg::H_RES,
    parameter int V_RES    = plot_pkg::V_RES,
    parameter int COLOUR_W = plot_pkg::COLOUR_W
) (
    input  wire logic  clk,
    input  wire logic  reset,
    plot_ctrl_if.slave bus
);
    import plot_pkg::*;

    localparam logic [X_W-1:0] c_X_LIMIT = X_W'(H_RES);
    localparam logic [Y_W-1:0] c_Y_LIMIT = Y_W'(V_RES);

    state_t              r_state;
    logic                r_pending;
    logic                r_line_ready;
    logic                r_clear_done;
    logic [COLOUR_W-1:0] r_fill_colour;
    logic [X_W-1:0]      r_vga_x;
    logic [Y_W-1:0]      r_vga_y;
    logic [COLOUR_W-1:0] r_vga_colour;
    logic                r_vga_plot;

    logic [X_W-1:0]      w_sweep_x;
    logic [Y_W-1:0]      w_sweep_y;
    logic                w_sweep_last;
    logic                w_sweep_en;
    logic                w_accept;
    logic                w_in_range;
    logic                w_clear_go;

    assign w_sweep_en = (r_state == ST_CLEAR);
    assign w_accept   = bus.line_valid && r_line_ready;
    assign w_in_range = (bus.line_x < c_X_LIMIT) && (bus.line_y < c_Y_LIMIT);
    // A clear either arrives now or is already latched; it beats line traffic.
    assign w_clear_go = bus.clear_req || r_pending;

    xy_sweep #(
        .H_RES (H_RES),
        .V_RES (V_RES),
        .X_W   (X_W),
        .Y_W   (Y_W)
    ) u_sweep (
        .clk   (clk),
        .reset (reset),
        .en    (w_sweep_en),
        .x     (w_sweep_x),
        .y     (w_sweep_y),
        .last  (w_sweep_last)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= ST_IDLE;
            r_pending     <= 1'b0;
            r_line_ready  <= 1'b0;
            r_clear_done  <= 1'b0;
            r_fill_colour <= '0;
            r_vga_x       <= '0;
            r_vga_y       <= '0;
            r_vga_colour  <= '0;
            r_vga_plot    <= 1'b0;
        end else begin
            r_clear_done <= 1'b0;

            // Plot path. line_ready is never high in CLEAR, so an accepted
            // pixel and a sweep pixel can never compete for the same cycle.
            // Off-screen pixels complete the handshake but are dropped here.
            if (w_accept) begin
                r_vga_plot <= w_in_range;
                if (w_in_range) begin
                    r_vga_x      <= bus.line_x;
                    r_vga_y      <= bus.line_y;
                    r_vga_colour <= bus.line_colour;
                end
            end else if (r_state == ST_CLEAR) begin
                r_vga_plot   <= 1'b1;
                r_vga_x      <= w_sweep_x;
                r_vga_y      <= w_sweep_y;
                r_vga_colour <= r_fill_colour;
            end else begin
                r_vga_plot <= 1'b0;
            end

            case (r_state)
                ST_IDLE, ST_LINE: begin
                    if (w_clear_go) begin
                        // Ready drops with the state change so no further
                        // pixel is taken once a clear has been requested.
                        r_state      <= ST_CLEAR;
                        r_pending    <= 1'b1;
                        r_line_ready <= 1'b0;
                        if (bus.clear_req) begin
                            r_fill_colour <= bus.clear_colour;
                        end
                    end else begin
                        r_line_ready <= 1'b1;
                        if ((r_state == ST_IDLE) && bus.line_valid) begin
                            r_state <= ST_LINE;
                        end else if ((r_state == ST_LINE) && !bus.line_valid) begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                ST_CLEAR: begin
                    // Requests during the sweep are ignored: neither the
                    // pending flag nor the fill colour is touched again.
                    r_pending <= 1'b0;
                    if (w_sweep_last) begin
                        r_state      <= ST_IDLE;
                        r_clear_done <= 1'b1;
                        r_line_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_pending    <= 1'b0;
                    r_line_ready <= 1'b0;
                end
            endcase
        end
    end

    assign bus.line_ready = r_line_ready;
    assign bus.busy       = r_pending || (r_state == ST_CLEAR);
    assign bus.clear_done = r_clear_done;
    assign bus.vga_x      = r_vga_x;
    assign bus.vga_y      = r_vga_y;
    assign bus.vga_colour = r_vga_colour;
    assign bus.vga_plot   = r_vga_plot;

endmodule
`default_nettype wire

// File: tb/tb_plot_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_plot_ctrl
//  Description : Self-checking bench for plot_ctrl: reset values, line pixel
//                table, full clears, clear preempting a line burst, ignored
//                second clear and reset during a clear.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_plot_ctrl;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    plot_ctrl_if #(.COLOUR_W(3)) bus ();

    plot_ctrl #(
        .H_RES    (160),
        .V_RES    (120),
        .COLOUR_W (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int oor_cnt  = 0;

    typedef struct {
        logic       valid;
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] col;
        logic       exp_plot;
    } vec_t;

    vec_t vecs [13];

    // Any plot outside the visible screen is an error, whenever it happens.
    always @(negedge clk) begin
        if (bus.vga_plot && ((int'(bus.vga_x) >= 160) || (int'(bus.vga_y) >= 120)))
            oor_cnt++;
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Follows a clear sweep one negedge at a time. Plot k must be at
    // (k%160, k/160) in colour col. Optionally injects a second clear_req
    // after req_at plots, or pulls reset after rst_at plots.
    task automatic watch(input logic [2:0] col, input int req_at, input int rst_at,
                         output int plots, output int dones, output int errs,
                         output int busy_done, output int lx, output int ly,
                         output int abort_plot, output int abort_done);
        plots = 0; dones = 0; errs = 0; busy_done = 1; lx = -1; ly = -1;
        abort_plot = -1; abort_done = -1;
        for (int cyc = 0; cyc < 19400; cyc++) begin
            @(negedge clk);
            bus.clear_req = 1'b0;
            if (bus.vga_plot) begin
                if (int'(bus.vga_x) != plots % 160 || int'(bus.vga_y) != plots / 160 ||
                    bus.vga_colour != col)
                    errs++;
                lx = int'(bus.vga_x);
                ly = int'(bus.vga_y);
                plots++;
            end
            if (bus.clear_done) begin
                dones++;
                busy_done = int'(bus.busy);
                break;
            end
            if (bus.line_ready || !bus.busy) errs++;
            if (plots == req_at) begin
                bus.clear_req    = 1'b1;
                bus.clear_colour = 3'b101;
            end
            if (plots == rst_at) begin
                reset = 1'b0;
                @(negedge clk);
                abort_plot = int'(bus.vga_plot);
                abort_done = int'(bus.clear_done);
                break;
            end
        end
    endtask

    initial begin
        int plots, dones, errs, busy_done, lx, ly, abort_plot, abort_done;
        int tail_err, tail_plots;

        vecs[0]  = '{1'b1, 8'd10,  7'd20,  3'd4, 1'b1};
        vecs[1]  = '{1'b1, 8'd11,  7'd20,  3'd4, 1'b1};
        vecs[2]  = '{1'b1, 8'd12,  7'd20,  3'd4, 1'b1};
        vecs[3]  = '{1'b1, 8'd13,  7'd20,  3'd4, 1'b1};
        vecs[4]  = '{1'b1, 8'd14,  7'd20,  3'd4, 1'b1};
        vecs[5]  = '{1'b0, 8'd0,   7'd0,   3'd0, 1'b0};
        vecs[6]  = '{1'b1, 8'd160, 7'd5,   3'd7, 1'b0};
        vecs[7]  = '{1'b1, 8'd3,   7'd120, 3'd7, 1'b0};
        vecs[8]  = '{1'b0, 8'd0,   7'd0,   3'd0, 1'b0};
        vecs[9]  = '{1'b1, 8'd159, 7'd119, 3'd1, 1'b1};
        vecs[10] = '{1'b1, 8'd0,   7'd0,   3'd6, 1'b1};
        vecs[11] = '{1'b1, 8'd255, 7'd127, 3'd2, 1'b0};
        vecs[12] = '{1'b0, 8'd0,   7'd0,   3'd0, 1'b0};

        bus.clear_req    = 1'b0;
        bus.clear_colour = 3'd0;
        bus.line_valid   = 1'b0;
        bus.line_x       = 8'd0;
        bus.line_y       = 7'd0;
        bus.line_colour  = 3'd0;

        // Reset values
        step(); step();
        check("rst_plot",       int'(bus.vga_plot),   0);
        check("rst_x",          int'(bus.vga_x),      0);
        check("rst_y",          int'(bus.vga_y),      0);
        check("rst_colour",     int'(bus.vga_colour), 0);
        check("rst_done",       int'(bus.clear_done), 0);
        check("rst_busy",       int'(bus.busy),       0);
        check("rst_ready",      int'(bus.line_ready), 0);
        reset = 1'b1;
        step();
        check("rel_ready",      int'(bus.line_ready), 1);
        check("rel_busy",       int'(bus.busy),       0);

        // Full clear in colour 010; colour input changes after acceptance
        bus.clear_req    = 1'b1;
        bus.clear_colour = 3'b010;
        step();
        bus.clear_req    = 1'b0;
        bus.clear_colour = 3'b111;
        check("clr1_busy",      int'(bus.busy),       1);
        check("clr1_ready",     int'(bus.line_ready), 0);
        watch(3'b010, -1, -1, plots, dones, errs, busy_done, lx, ly, abort_plot, abort_done);
        check("clr1_plots",     plots,     19200);
        check("clr1_dones",     dones,     1);
        check("clr1_errs",      errs,      0);
        check("clr1_busy_done", busy_done, 0);
        check("clr1_last_x",    lx,        159);
        check("clr1_last_y",    ly,        119);
        step();
        check("clr1_done_pulse", int'(bus.clear_done), 0);
        check("clr1_busy_after", int'(bus.busy),       0);
        check("clr1_plot_after", int'(bus.vga_plot),   0);
        check("clr1_ready_after", int'(bus.line_ready), 1);

        // Line pixel table, one vector per cycle
        for (int i = 0; i < 13; i++) begin
            bus.line_valid  = vecs[i].valid;
            bus.line_x      = vecs[i].x;
            bus.line_y      = vecs[i].y;
            bus.line_colour = vecs[i].col;
            @(negedge clk);
            check($sformatf("vec%0d_ready", i), int'(bus.line_ready), 1);
            step();
            check($sformatf("vec%0d_plot", i), int'(bus.vga_plot), int'(vecs[i].exp_plot));
            if (vecs[i].exp_plot) begin
                check($sformatf("vec%0d_x", i),   int'(bus.vga_x),      int'(vecs[i].x));
                check($sformatf("vec%0d_y", i),   int'(bus.vga_y),      int'(vecs[i].y));
                check($sformatf("vec%0d_col", i), int'(bus.vga_colour), int'(vecs[i].col));
            end
        end

        // Clear requested together with pixel 3 of a 10-pixel burst
        for (int p = 0; p < 3; p++) begin
            bus.line_valid  = 1'b1;
            bus.line_x      = 8'(30 + p);
            bus.line_y      = 7'd50;
            bus.line_colour = 3'd5;
            if (p == 2) begin
                bus.clear_req    = 1'b1;
                bus.clear_colour = 3'b001;
            end
            step();
            check($sformatf("burst_p%0d_plot", p), int'(bus.vga_plot), 1);
            check($sformatf("burst_p%0d_x", p),    int'(bus.vga_x),    30 + p);
        end
        bus.clear_req = 1'b0;
        check("burst_ready_drop", int'(bus.line_ready), 0);
        check("burst_busy",       int'(bus.busy),       1);
        bus.line_x = 8'd33;
        @(negedge clk);
        watch(3'b001, -1, -1, plots, dones, errs, busy_done, lx, ly, abort_plot, abort_done);
        check("burst_clr_plots", plots, 19200);
        check("burst_clr_dones", dones, 1);
        check("burst_clr_errs",  errs,  0);
        tail_err = 0;
        tail_plots = 0;
        for (int p = 3; p < 10; p++) begin
            step();
            if (bus.vga_plot && int'(bus.vga_x) == 30 + p && int'(bus.vga_y) == 50 &&
                bus.vga_colour == 3'd5)
                tail_plots++;
            else
                tail_err++;
            if (p < 9) bus.line_x = 8'(30 + p + 1);
            else       bus.line_valid = 1'b0;
        end
        check("burst_tail_plots", tail_plots, 7);
        check("burst_tail_err",   tail_err,   0);
        step();
        check("burst_end_plot",   int'(bus.vga_plot), 0);

        // Second clear_req at sweep pixel 500 is ignored
        bus.clear_req    = 1'b1;
        bus.clear_colour = 3'b011;
        step();
        bus.clear_req = 1'b0;
        watch(3'b011, 500, -1, plots, dones, errs, busy_done, lx, ly, abort_plot, abort_done);
        check("dbl_plots", plots, 19200);
        check("dbl_dones", dones, 1);
        check("dbl_errs",  errs,  0);
        step(); step();
        check("dbl_busy_after", int'(bus.busy),     0);
        check("dbl_plot_after", int'(bus.vga_plot), 0);

        // Reset at sweep pixel 1000 aborts, next clear restarts at (0,0)
        bus.clear_req    = 1'b1;
        bus.clear_colour = 3'b110;
        step();
        bus.clear_req = 1'b0;
        watch(3'b110, -1, 1000, plots, dones, errs, busy_done, lx, ly, abort_plot, abort_done);
        check("abort_plots",     plots,      1000);
        check("abort_errs",      errs,       0);
        check("abort_dones",     dones,      0);
        check("abort_vga_plot",  abort_plot, 0);
        check("abort_clr_done",  abort_done, 0);
        check("abort_busy",      int'(bus.busy),       0);
        check("abort_ready",     int'(bus.line_ready), 0);
        step();
        reset = 1'b1;
        step();
        check("restart_ready",   int'(bus.line_ready), 1);
        check("restart_done",    int'(bus.clear_done), 0);
        bus.clear_req    = 1'b1;
        bus.clear_colour = 3'b001;
        step();
        bus.clear_req = 1'b0;
        watch(3'b001, -1, 5, plots, dones, errs, busy_done, lx, ly, abort_plot, abort_done);
        check("restart_plots",   plots, 5);
        check("restart_errs",    errs,  0);
        step();
        reset = 1'b1;
        step();

        check("out_of_range_plots", oor_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
